pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
Consumer stage for the UART pixel loader. Accepts 24-bit RGB pixels, each qualified by a one-cycle valid pulse. Buffers the pixels in a small FIFO and writes them into the SDRAM frame buffer through an Avalon-MM master write port, one 32-bit word per pixel, in raster order. Wraps to the frame base after WIDTH*HEIGHT pixels and reports frame completion and overflow.

Parameters:
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame
BASE_ADDR, 0, byte address of pixel 0
ADDR_W, 25, Avalon byte address width
FIFO_DEPTH, 8, pixel FIFO entries (power of 2, >=2)

Ports:
avm_clk  in  1  single clock for all logic
avm_rst  in  1  synchronous, active-high reset
i_data  in  24  pixel {B[23:16],G[15:8],R[7:0]} as assembled upstream
i_valid  in  1  one-cycle pixel strobe; no backpressure to source
avm_address  out  ADDR_W  write byte address
avm_write  out  1  write request
avm_writedata  out  32  {8'h00, pixel}
avm_waitrequest  in  1  slave stall
o_frame_done  out  1  one-cycle pulse when last pixel of a frame is accepted
o_overflow  out  1  sticky: a pixel was dropped
o_busy  out  1  FIFO non-empty or write outstanding

Behaviour:
- Clock and reset: one clock avm_clk; reset avm_rst is synchronous and active-high.
- Reset values: avm_write=0, avm_address=BASE_ADDR, avm_writedata=0, o_frame_done=0, o_overflow=0, o_busy=0. FIFO is empty, pixel counter=0, state=S_IDLE.
- Reset asserted mid-write drops avm_write at the next edge, flushes the FIFO and restarts at pixel 0.
- FIFO push: on i_valid when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the pixel is discarded and o_overflow is set until reset.
- States, registered Avalon outputs:
  - S_IDLE: if FIFO non-empty, pop the head and load avm_writedata and avm_address = BASE_ADDR + 4*pix_cnt. Set avm_write=1 and go to S_WRITE.
  - S_WRITE: hold address, data and write stable while avm_waitrequest=1. On the first cycle with avm_write=1 and avm_waitrequest=0 (acceptance):
    - If FIFO non-empty, pop the next pixel and present it on the following cycle with avm_write kept high (back-to-back, stay in S_WRITE).
    - Else drop avm_write and go to S_IDLE.
- Latency: i_valid in cycle k with an idle, empty writer puts avm_write high in cycle k+2.
- Counter and address: pix_cnt increments on each acceptance. When the accepted pixel is pix_cnt==WIDTH*HEIGHT-1:
  - pix_cnt wraps to 0 and the next address is BASE_ADDR.
  - o_frame_done pulses for exactly the cycle after that acceptance.
- Address arithmetic is modulo 2^ADDR_W.
- Write ordering strictly matches pixel arrival order.
- o_busy = (FIFO count != 0) | avm_write.

Optional Feature:
Macro PIXEL_WRITER_RGB565_EN.
- Defined: avm_writedata = {16'h0000, R[7:3], G[7:2], B[7:3]} packed as bits [15:11]=R, [10:5]=G, [4:0]=B. Address stride is 2 bytes (address = BASE_ADDR + 2*pix_cnt).
- Undefined: 24-bit pass-through, stride 4, as specified above.

Test Plan:
- Reset, then i_valid with i_data=24'hA1B2C3 in cycle 5, waitrequest=0 -> avm_write=1 in cycle 7 only, avm_address=BASE_ADDR, avm_writedata=32'h00A1B2C3, o_busy falls after acceptance.
- Three pulses spaced 3 cycles apart; waitrequest held high 4 cycles on the second write -> address and data held stable while stalled, writes land at BASE+0, +4, +8 in order, o_overflow=0.
- WIDTH=4, HEIGHT=2, 9 pixels -> o_frame_done pulses once after the 8th acceptance, 9th pixel written at BASE_ADDR.
- FIFO_DEPTH=8, waitrequest=1 held, 10 consecutive i_valid -> first pixel is on the bus, the next 8 are buffered, the 10th is dropped and o_overflow=1 and stays 1. After release, 9 writes occur.
- Full FIFO with acceptance coinciding with i_valid -> pixel accepted, o_overflow stays 0.
- avm_rst asserted while avm_write=1 and waitrequest=1 -> avm_write=0 at the next edge, address=BASE_ADDR, queued pixels lost, o_overflow cleared.

Source files
------------

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: buffers strobed RGB pixels in a small FIFO and writes them,
// one word per pixel in raster order, into a frame buffer over an Avalon-MM master.
// Ports: avm_clk/avm_rst (sync, active-high); i_data/i_valid pixel input (no backpressure);
// avm_address/avm_write/avm_writedata/avm_waitrequest Avalon write master;
// o_frame_done (pulse after last pixel of a frame accepted), o_overflow (sticky drop),
// o_busy (FIFO non-empty or write outstanding).
// Define PIXEL_WRITER_RGB565_EN to pack pixels as RGB565 with a 2-byte address stride.
module pixel_frame_writer #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W = 25,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  input  logic [23:0]       i_data,
  input  logic              i_valid,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_busy
);
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int CNT_W = FRAME > 1 ? $clog2(FRAME) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef PIXEL_WRITER_RGB565_EN
  localparam int SHIFT = 1;
`else
  localparam int SHIFT = 2;
`endif
  typedef enum logic {S_IDLE, S_WRITE} state_t;
  state_t state_q, state_d;
  logic [23:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0] count_q, count_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d, head_word;
  logic [23:0] head;
  logic write_q, write_d, done_q, ovf_q;
  logic accept, last, pop, push;
  assign head = mem_q[rd_ptr_q];
`ifdef PIXEL_WRITER_RGB565_EN
  assign head_word = {16'h0000, head[7:3], head[15:10], head[23:19]};
`else
  assign head_word = {8'h00, head};
`endif
  assign accept = write_q & ~avm_waitrequest;
  assign last = pix_cnt_q == CNT_W'(FRAME - 1);
  // Pop whenever the bus is free: idle, or the current word is accepted this cycle.
  assign pop = (count_q != '0) & (state_q == S_IDLE | accept);
  // A full FIFO still takes a pixel when a pop frees a slot in the same cycle.
  assign push = i_valid & ((count_q != (PTR_W+1)'(FIFO_DEPTH)) | pop);
  assign count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign pix_cnt_d = accept ? (last ? '0 : pix_cnt_q + 1'b1) : pix_cnt_q;
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      state_d = S_WRITE;
      write_d = 1'b1;
      addr_d = ADDR_W'(BASE_ADDR) + (ADDR_W'(pix_cnt_d) << SHIFT);
      data_d = head_word;
    end else if (accept) begin
      state_d = S_IDLE;
      write_d = 1'b0;
    end
  end
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q <= ADDR_W'(BASE_ADDR);
      data_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= accept & last;
      ovf_q <= ovf_q | (i_valid & ~push);
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      pix_cnt_q <= pix_cnt_d;
    end
  end
  always_ff @(posedge avm_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end
  assign avm_address = addr_q;
  assign avm_write = write_q;
  assign avm_writedata = data_q;
  assign o_frame_done = done_q;
  assign o_overflow = ovf_q;
  assign o_busy = (count_q != '0) | write_q;
endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb_pixel_frame_writer: directed and random stimulus against a queue-based reference model.
module tb_pixel_frame_writer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int FRAME = W * H;
  localparam int BASE = 'h100;
  localparam int AW = 25;
  localparam int D = 8;
`ifdef PIXEL_WRITER_RGB565_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 4;
`endif
  logic avm_clk = 1'b0;
  logic avm_rst = 1'b1;
  logic [23:0] i_data = '0;
  logic i_valid = 1'b0;
  logic [AW-1:0] avm_address;
  logic avm_write;
  logic [31:0] avm_writedata;
  logic avm_waitrequest = 1'b0;
  logic o_frame_done, o_overflow, o_busy;
  int n_assert = 0;
  int n_fail = 0;
  int n_done = 0;
  int dut_acc = 0;
  logic [23:0] m_q [$];
  logic [23:0] sb [$];
  logic m_write, m_done, m_ovf;
  logic [AW-1:0] m_addr;
  logic [31:0] m_data;
  int m_cnt, n_acc;

  pixel_frame_writer #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .i_data(i_data), .i_valid(i_valid),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .o_frame_done(o_frame_done),
    .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 avm_clk = ~avm_clk;

  function automatic logic [31:0] word(input logic [23:0] p);
`ifdef PIXEL_WRITER_RGB565_EN
    return {16'h0000, p[7:3], p[15:10], p[23:19]};
`else
    return {8'h00, p};
`endif
  endfunction

  function automatic logic [AW-1:0] addr_of(input int idx);
    return AW'(BASE + STRIDE * idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    sb.delete();
    m_write = 1'b0;
    m_done = 1'b0;
    m_ovf = 1'b0;
    m_addr = AW'(BASE);
    m_data = '0;
    m_cnt = 0;
    n_acc = 0;
    dut_acc = 0;
    n_done = 0;
  endtask

  task automatic check_all();
    chk("write", 32'(avm_write), 32'(m_write));
    chk("addr", 32'(avm_address), 32'(m_addr));
    chk("data", avm_writedata, m_data);
    chk("frame_done", 32'(o_frame_done), 32'(m_done));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("busy", 32'(o_busy), 32'(m_q.size() != 0 || m_write));
    if (o_frame_done) n_done++;
  endtask

  // One clock: drive inputs, advance the model over the coming edge, then compare.
  task automatic step(input logic v, input logic [23:0] d, input logic w);
    bit acc, pop, push, last;
    i_valid = v;
    i_data = d;
    avm_waitrequest = w;
    acc = m_write && !w;
    if (avm_write && !w) dut_acc++;
    if (acc) begin
      chk("sb_addr", 32'(avm_address), 32'(addr_of(n_acc % FRAME)));
      chk("sb_data", avm_writedata, word(sb.pop_front()));
      n_acc++;
    end
    pop = m_q.size() > 0 && (!m_write || acc);
    push = v && (m_q.size() < D || pop);
    last = acc && m_cnt == FRAME - 1;
    if (acc) m_cnt = last ? 0 : m_cnt + 1;
    m_done = last;
    if (v && !push) m_ovf = 1'b1;
    if (pop) begin
      m_write = 1'b1;
      m_data = word(m_q.pop_front());
      m_addr = addr_of(m_cnt);
    end else if (acc) m_write = 1'b0;
    if (push) begin
      m_q.push_back(d);
      sb.push_back(d);
    end
    @(posedge avm_clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic w);
    avm_rst = 1'b1;
    i_valid = 1'b0;
    avm_waitrequest = w;
    @(posedge avm_clk);
    #1;
    avm_rst = 1'b0;
    model_clear();
    check_all();
  endtask

  initial begin
    model_clear();
    do_reset(1'b0);
    // Single pixel latency and completion.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 24'hA1B2C3, 1'b0);
    chk("lat_k1_write", 32'(avm_write), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("lat_k2_write", 32'(avm_write), 32'd1);
    chk("lat_k2_addr", 32'(avm_address), 32'(BASE));
    chk("lat_k2_data", avm_writedata, word(24'hA1B2C3));
    step(1'b0, '0, 1'b0);
    chk("single_done_write", 32'(avm_write), 32'd0);
    chk("single_busy", 32'(o_busy), 32'd0);
    // Three spaced pixels, second write stalled for four cycles.
    do_reset(1'b0);
    for (int i = 0; i < 13; i++)
      step(i % 3 == 0 && i < 9, 24'h110000 + 24'(i), i >= 5 && i < 9);
    chk("spaced_acc", 32'(dut_acc), 32'd3);
    chk("spaced_ovf", 32'(o_overflow), 32'd0);
    // Frame wrap: nine back-to-back pixels.
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 24'h200000 + 24'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    chk("wrap_done_cnt", 32'(n_done), 32'd1);
    chk("wrap_acc", 32'(dut_acc), 32'd9);
    chk("wrap_last_addr", 32'(avm_address), 32'(BASE));
    // Overflow: stalled bus, ten pixels, tenth dropped.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 24'h300000 + 24'(i), 1'b1);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b0);
    chk("ovf_acc", 32'(dut_acc), 32'd9);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
    // Full FIFO with acceptance on the same cycle as a new pixel.
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 24'h400000 + 24'(i), 1'b1);
    step(1'b1, 24'h4000FF, 1'b0);
    chk("full_pop_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b0);
    chk("full_pop_acc", 32'(dut_acc), 32'd10);
    // Reset mid-write with stalled bus and an overflowed FIFO.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 24'h500000 + 24'(i), 1'b1);
    do_reset(1'b1);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'(BASE));
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    step(1'b1, 24'h5A5A5A, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    chk("rst_after_acc", 32'(dut_acc), 32'd1);
    // Random traffic.
    do_reset(1'b0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, 24'($urandom), $urandom_range(0, 9) < 3);
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0);
    chk("rand_drained", 32'(o_busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
